// File: rtl/fft_mul_seq_ctrl_if.sv
// Handshake bundle between the upstream stage controller (master) and the
// butterfly-multiplier sequencer (slave).
interface fft_mul_seq_ctrl_if #(
    parameter int SEL_W = 2,
    parameter int PH_W  = 1
);
    logic             en;
    logic             cont;
    logic             clr;
    logic             mul_en;
    logic [SEL_W-1:0] mul_sel;
    logic [PH_W-1:0]  phase_idx;
    logic             start_pulse;
    logic             frame_done;
    logic             busy;
    logic             overrun;

    modport master (
        output en, cont, clr,
        input  mul_en, mul_sel, phase_idx, start_pulse, frame_done, busy, overrun
    );
    modport slave (
        input  en, cont, clr,
        output mul_en, mul_sel, phase_idx, start_pulse, frame_done, busy, overrun
    );
endinterface

// File: rtl/fft_mul_seq_ctrl.sv
// Sequencer for one FFT butterfly-multiplier stage: walks N_PHASE phases of
// SEL_PER_PHASE select slots, BURST_LEN cycles each, with registered outputs.
module fft_mul_seq_ctrl #(
    parameter int N_PHASE       = 2,
    parameter int SEL_PER_PHASE = 2,
    parameter int BURST_LEN     = 4
) (
    input logic               clk,
    input logic               rstn,
    fft_mul_seq_ctrl_if.slave bus
);
    localparam int SEL_W = (N_PHASE * SEL_PER_PHASE > 1) ? $clog2(N_PHASE * SEL_PER_PHASE) : 1;
    localparam int PH_W  = (N_PHASE > 1) ? $clog2(N_PHASE) : 1;
    localparam int BW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int SW    = (SEL_PER_PHASE > 1) ? $clog2(SEL_PER_PHASE) : 1;

    localparam logic [BW-1:0]   B_LAST = BW'(BURST_LEN - 1);
    localparam logic [SW-1:0]   S_LAST = SW'(SEL_PER_PHASE - 1);
    localparam logic [PH_W-1:0] P_LAST = PH_W'(N_PHASE - 1);

    typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;

    state_t           state, state_n;
    logic [BW-1:0]    burst_cnt, burst_n;
    logic [SW-1:0]    slot_cnt, slot_n;
    logic [PH_W-1:0]  phase_q, phase_n;
    logic [SEL_W-1:0] sel_q, sel_n;
    logic             mul_en_q, mul_en_n;
    logic             busy_q, busy_n;
    logic             start_q, start_n;
    logic             done_q, done_n;
    logic             ovr_q, ovr_n;

    logic last_burst, last_slot, last_phase;
    assign last_burst = (burst_cnt == B_LAST);
    assign last_slot  = (slot_cnt == S_LAST);
    assign last_phase = (phase_q == P_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            burst_cnt <= '0;
            slot_cnt  <= '0;
            phase_q   <= '0;
            sel_q     <= '0;
            mul_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state     <= state_n;
            burst_cnt <= burst_n;
            slot_cnt  <= slot_n;
            phase_q   <= phase_n;
            sel_q     <= sel_n;
            mul_en_q  <= mul_en_n;
            busy_q    <= busy_n;
            start_q   <= start_n;
            done_q    <= done_n;
            ovr_q     <= ovr_n;
        end
    end

    always_comb begin
        state_n = state;
        if (bus.clr) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE, WAIT: if (bus.en) state_n = RUN;
                RUN: begin
                    if (last_burst && last_slot) begin
                        if (last_phase)    state_n = IDLE;
                        else if (!bus.cont) state_n = WAIT;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs and counters. At end of a
    // non-final phase mul_sel steps to the next phase's first select, so WAIT
    // already presents it.
    always_comb begin
        burst_n  = burst_cnt;
        slot_n   = slot_cnt;
        phase_n  = phase_q;
        sel_n    = sel_q;
        mul_en_n = mul_en_q;
        busy_n   = busy_q;
        start_n  = 1'b0;
        done_n   = 1'b0;
        ovr_n    = ovr_q | ((state == RUN) && bus.en);
        if (bus.clr) begin
            burst_n  = '0;
            slot_n   = '0;
            phase_n  = '0;
            sel_n    = '0;
            mul_en_n = 1'b0;
            busy_n   = 1'b0;
            ovr_n    = 1'b0;
        end else if (state != RUN) begin
            if (bus.en) begin
                mul_en_n = 1'b1;
                busy_n   = 1'b1;
                start_n  = 1'b1;
                burst_n  = '0;
                slot_n   = '0;
            end
        end else begin
            burst_n = last_burst ? '0 : burst_cnt + 1'b1;
            if (last_burst) begin
                slot_n = last_slot ? '0 : slot_cnt + 1'b1;
                if (!last_slot) begin
                    sel_n = sel_q + 1'b1;
                end else if (last_phase) begin
                    phase_n  = '0;
                    sel_n    = '0;
                    mul_en_n = 1'b0;
                    busy_n   = 1'b0;
                    done_n   = 1'b1;
                end else begin
                    phase_n = phase_q + 1'b1;
                    sel_n   = sel_q + 1'b1;
                    if (bus.cont) begin
                        start_n = 1'b1;
                    end else begin
                        mul_en_n = 1'b0;
                        busy_n   = 1'b0;
                    end
                end
            end
        end
    end

    assign bus.mul_en      = mul_en_q;
    assign bus.mul_sel     = sel_q;
    assign bus.phase_idx   = phase_q;
    assign bus.start_pulse = start_q;
    assign bus.frame_done  = done_q;
    assign bus.busy        = busy_q;
    assign bus.overrun     = ovr_q;
endmodule

// File: tb/tb_fft_mul_seq_ctrl.sv
// Bench for fft_mul_seq_ctrl: default geometry (2/2/4) and a 4/1/2 instance,
// checked cycle by cycle against a phase/position reference model.
module tb_fft_mul_seq_ctrl;
    localparam int NA = 2, SA = 2, BA = 4;
    localparam int NB = 4, SB = 1, BB = 2;

    logic clk, rstn;
    int   nchk, nerr;

    fft_mul_seq_ctrl_if #(.SEL_W(2), .PH_W(1)) ia ();
    fft_mul_seq_ctrl_if #(.SEL_W(2), .PH_W(2)) ib ();

    fft_mul_seq_ctrl #(.N_PHASE(NA), .SEL_PER_PHASE(SA), .BURST_LEN(BA)) dut_a (
        .clk(clk), .rstn(rstn), .bus(ia.slave));
    fft_mul_seq_ctrl #(.N_PHASE(NB), .SEL_PER_PHASE(SB), .BURST_LEN(BB)) dut_b (
        .clk(clk), .rstn(rstn), .bus(ib.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: running flag, position within the phase, phase number.
    typedef struct {int run; int pos; int ph; int ovr; int st; int dn;} mdl_t;
    mdl_t ma, mb;

    function automatic mdl_t step(mdl_t m, int n, int s, int b, bit en, bit cont, bit clr);
        mdl_t r;
        r = m;
        r.st = 0;
        r.dn = 0;
        if (clr) begin
            r = '{default: 0};
        end else if (m.run != 0) begin
            if (en) r.ovr = 1;
            if (m.pos == s * b - 1) begin
                r.pos = 0;
                if (m.ph == n - 1) begin
                    r.run = 0; r.ph = 0; r.dn = 1;
                end else begin
                    r.ph = m.ph + 1;
                    if (cont) r.st = 1;
                    else      r.run = 0;
                end
            end else begin
                r.pos = m.pos + 1;
            end
        end else if (en) begin
            r.run = 1; r.pos = 0; r.st = 1;
        end
        return r;
    endfunction

    function automatic logic [12:0] expv(mdl_t m, int s, int b);
        int sel;
        sel = (m.run != 0) ? m.ph * s + m.pos / b : m.ph * s;
        return {m.run[0], m.run[0], m.st[0], m.dn[0], m.ovr[0], 4'(m.ph), 4'(sel)};
    endfunction

    function automatic logic [12:0] obs_a();
        return {ia.mul_en, ia.busy, ia.start_pulse, ia.frame_done, ia.overrun,
                4'(ia.phase_idx), 4'(ia.mul_sel)};
    endfunction

    function automatic logic [12:0] obs_b();
        return {ib.mul_en, ib.busy, ib.start_pulse, ib.frame_done, ib.overrun,
                4'(ib.phase_idx), 4'(ib.mul_sel)};
    endfunction

    task automatic tick(bit ea, bit ca, bit xa, bit eb, bit cb, bit xb);
        ia.en = ea; ia.cont = ca; ia.clr = xa;
        ib.en = eb; ib.cont = cb; ib.clr = xb;
        @(posedge clk);
        ma = step(ma, NA, SA, BA, ea, ca, xa);
        mb = step(mb, NB, SB, BB, eb, cb, xb);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        ia.en = 0; ia.cont = 0; ia.clr = 0;
        ib.en = 0; ib.cont = 0; ib.clr = 0;
        ma = '{default: 0};
        mb = '{default: 0};
        repeat (2) @(posedge clk);
        #1;
        nchk++;
        if (obs_a() !== 13'h0) begin nerr++; $display("FAIL reset_a got %h want 0", obs_a()); end
        nchk++;
        if (obs_b() !== 13'h0) begin nerr++; $display("FAIL reset_b got %h want 0", obs_b()); end
        rstn = 1'b1;
    endtask

    task automatic test_phase_seq();
        int en_cnt, done_cnt;
        en_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 22; c++) begin
            tick(c == 0 || c == 12, 0, 0, 0, 0, 0);
            en_cnt += int'(ia.mul_en);
            done_cnt += int'(ia.frame_done);
            nchk++;
            if (obs_a() !== expv(ma, SA, BA)) begin
                nerr++; $display("FAIL phase_seq cyc%0d got %h want %h", c + 1, obs_a(), expv(ma, SA, BA));
            end
            if (c + 1 == 9) begin
                nchk++;
                if ({ia.busy, ia.mul_en, ia.phase_idx, ia.frame_done} !== 4'b0010) begin
                    nerr++; $display("FAIL phase_seq_wait got %b want 0010",
                                     {ia.busy, ia.mul_en, ia.phase_idx, ia.frame_done});
                end
            end
            if (c + 1 == 21) begin
                nchk++;
                if ({ia.frame_done, ia.phase_idx, ia.mul_sel} !== 4'b1000) begin
                    nerr++; $display("FAIL phase_seq_done got %b want 1000",
                                     {ia.frame_done, ia.phase_idx, ia.mul_sel});
                end
            end
        end
        nchk++;
        if (en_cnt != 16 || done_cnt != 1) begin
            nerr++; $display("FAIL phase_seq_counts got en=%0d done=%0d want en=16 done=1", en_cnt, done_cnt);
        end
    endtask

    task automatic test_cont();
        int en_cnt;
        logic [17:0] starts, dones;
        en_cnt = 0; starts = '0; dones = '0;
        for (int c = 0; c < 18; c++) begin
            tick(c == 0, 1, 0, 0, 0, 0);
            en_cnt += int'(ia.mul_en);
            starts[c] = ia.start_pulse;
            dones[c] = ia.frame_done;
            nchk++;
            if (obs_a() !== expv(ma, SA, BA)) begin
                nerr++; $display("FAIL cont cyc%0d got %h want %h", c + 1, obs_a(), expv(ma, SA, BA));
            end
        end
        nchk++;
        if (en_cnt != 16 || starts != 18'h00101 || dones != 18'h10000) begin
            nerr++; $display("FAIL cont_shape got en=%0d st=%h dn=%h want en=16 st=00101 dn=10000",
                             en_cnt, starts, dones);
        end
    endtask

    task automatic test_overrun();
        for (int c = 0; c < 22; c++) begin
            tick(c == 0 || c == 5 || c == 12, 0, 0, 0, 0, 0);
            nchk++;
            if (obs_a() !== expv(ma, SA, BA)) begin
                nerr++; $display("FAIL overrun cyc%0d got %h want %h", c + 1, obs_a(), expv(ma, SA, BA));
            end
            if (c + 1 == 6 || c + 1 == 21) begin
                nchk++;
                if (ia.overrun !== 1'b1) begin
                    nerr++; $display("FAIL overrun_set cyc%0d got %b want 1", c + 1, ia.overrun);
                end
            end
        end
        tick(0, 0, 1, 0, 0, 0);
        nchk++;
        if (ia.overrun !== 1'b0 || obs_a() !== expv(ma, SA, BA)) begin
            nerr++; $display("FAIL overrun_clr got %h want %h", obs_a(), expv(ma, SA, BA));
        end
    endtask

    task automatic test_abort();
        int done_cnt;
        done_cnt = 0;
        for (int c = 0; c < 4; c++) tick(c == 0 || c == 3, 0, c == 3, 0, 0, 0);
        nchk++;
        if (obs_a() !== 13'h0) begin nerr++; $display("FAIL abort got %h want 0", obs_a()); end
        for (int c = 0; c < 10; c++) begin
            tick(0, 0, 0, 0, 0, 0);
            done_cnt += int'(ia.frame_done);
        end
        nchk++;
        if (done_cnt != 0) begin nerr++; $display("FAIL abort_nodone got %0d want 0", done_cnt); end
        tick(1, 0, 0, 0, 0, 0);
        nchk++;
        if (obs_a() !== 13'h1C00) begin nerr++; $display("FAIL abort_restart got %h want 1c00", obs_a()); end
        tick(0, 0, 1, 0, 0, 0);
    endtask

    task automatic test_degenerate();
        logic [3:0] want_sel;
        for (int c = 0; c < 10; c++) begin
            tick(0, 0, 0, c == 0, 1, 0);
            want_sel = (c < 8) ? 4'(c / 2) : 4'd0;
            nchk++;
            if (obs_b() !== expv(mb, SB, BB) || 4'(ib.mul_sel) !== want_sel ||
                ib.start_pulse !== (c < 8 && c % 2 == 0) || ib.frame_done !== (c == 8)) begin
                nerr++; $display("FAIL degen cyc%0d got %h want %h sel %0d", c + 1, obs_b(), expv(mb, SB, BB), want_sel);
            end
        end
        for (int c = 0; c < 4; c++) tick(0, 0, 0, c == 0, 1, 0);
        #2 rstn = 1'b0;
        #1;
        ma = '{default: 0};
        mb = '{default: 0};
        nchk++;
        if (obs_b() !== 13'h0 || obs_a() !== 13'h0) begin
            nerr++; $display("FAIL degen_reset got %h/%h want 0", obs_b(), obs_a());
        end
        #1 rstn = 1'b1;
    endtask

    task automatic test_random();
        bit ea, ca, xa, eb, cb, xb;
        for (int c = 0; c < 600; c++) begin
            ea = ($urandom_range(3) == 0); ca = 1'($urandom_range(1)); xa = ($urandom_range(40) == 0);
            eb = ($urandom_range(2) == 0); cb = 1'($urandom_range(1)); xb = ($urandom_range(40) == 0);
            tick(ea, ca, xa, eb, cb, xb);
            nchk++;
            if (obs_a() !== expv(ma, SA, BA)) begin
                nerr++; $display("FAIL random_a cyc%0d got %h want %h", c, obs_a(), expv(ma, SA, BA));
            end
            nchk++;
            if (obs_b() !== expv(mb, SB, BB)) begin
                nerr++; $display("FAIL random_b cyc%0d got %h want %h", c, obs_b(), expv(mb, SB, BB));
            end
        end
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        test_reset();
        tick(0, 0, 0, 0, 0, 0);
        test_phase_seq();
        test_cont();
        test_overrun();
        test_abort();
        test_degenerate();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/fft_mul_seq_ctrl.md
Name: fft_mul_seq_ctrl

Overview:
Parametrised sequencer for one FFT butterfly-multiplier stage. It drives the multiplier enable and the twiddle/multiplier-value select through a frame of N_PHASE phases. Each phase is SEL_PER_PHASE select slots of BURST_LEN cycles. It sits between the upstream stage controller, which issues `en` per phase, and the stage multiplier. Compared with the fixed 2-phase/2-select/4-cycle controller it adds:
- parametrised geometry
- a continuous (back-to-back) mode
- frame-done and busy status
- overrun detection
- synchronous abort

Parameters:
N_PHASE, 2, phases per frame (>=1)
SEL_PER_PHASE, 2, select slots per phase (>=1)
BURST_LEN, 4, cycles per select slot (>=1)
SEL_W, max(1,$clog2(N_PHASE*SEL_PER_PHASE)), derived, select width
PH_W, max(1,$clog2(N_PHASE)), derived, phase index width

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
en  in  1  phase start request, level sampled each edge
cont  in  1  1 = run all phases of a frame back-to-back without waiting for en
clr  in  1  synchronous abort/clear
mul_en  out  1  multiplier enable
mul_sel  out  SEL_W  multiplier value select
phase_idx  out  PH_W  current/next phase number
start_pulse  out  1  one-cycle strobe on first cycle of each phase (downstream alert)
frame_done  out  1  one-cycle strobe after last phase of frame
busy  out  1  1 while in RUN
overrun  out  1  sticky: en seen while RUN

Behaviour:
- All outputs are registered. Reset (rstn=0, async) sets state=IDLE, counters 0, and all outputs 0.
- States:
  - IDLE: awaiting phase 0.
  - RUN: issuing select slots.
  - WAIT: between phases, awaiting en.
- Counters:
  - burst_cnt runs 0..BURST_LEN-1.
  - slot_cnt runs 0..SEL_PER_PHASE-1.
  - phase_idx runs 0..N_PHASE-1.
- IDLE/WAIT with en=1 at edge k, then from edge k onward:
  - state=RUN, mul_en=1, busy=1.
  - mul_sel = phase_idx*SEL_PER_PHASE.
  - start_pulse=1 for exactly one cycle.
  - Latency from en to mul_en: 1 edge.
- RUN:
  - burst_cnt increments every cycle.
  - When burst_cnt==BURST_LEN-1, burst_cnt wraps to 0 and slot_cnt increments. mul_sel increments at the same edge if the phase is not finished.
  - mul_en is high for exactly SEL_PER_PHASE*BURST_LEN consecutive cycles per phase.
- End of phase, on the last burst cycle of the last slot:
  - Not last phase, cont=0: next state WAIT, mul_en=0, busy=0, phase_idx+1.
  - Not last phase, cont=1: stay in RUN, mul_en stays 1, phase_idx+1, mul_sel continues to the next value, start_pulse=1 on the first cycle of the new phase. There is no gap cycle.
  - Last phase: next state IDLE, mul_en=0, busy=0, phase_idx=0, mul_sel=0. frame_done=1 for one cycle, coincident with the first mul_en=0 cycle.
- cont is sampled only on the end-of-phase cycle.
- In WAIT, phase_idx and mul_sel hold. mul_sel already shows the next phase's first select.
- en in RUN, including the end-of-phase cycle, is ignored and sets overrun=1. It never retriggers or extends a phase.
- overrun stays set until clr or reset.
- en held high continuously in IDLE/WAIT starts exactly one phase per acceptance. Re-acceptance is only possible after RUN exits.
- clr=1 (any state) at the next edge:
  - state=IDLE; all counters, mul_en, mul_sel, phase_idx, start_pulse, frame_done, busy and overrun become 0.
  - clr has priority over en in the same cycle.
  - No frame_done is generated for an aborted frame.
- Degenerate geometry:
  - BURST_LEN=1: mul_sel changes every cycle.
  - SEL_PER_PHASE=1: one select per phase.
  - N_PHASE=1: every phase ends the frame, and WAIT is never entered.
- Counter widths must not overflow for any legal parameter combination, including power-of-two values.

Test Plan:
- Defaults, cont=0, en pulse at cycle 0 -> mul_en=1 cycles 1-8; mul_sel=0 (cycles 1-4), 1 (5-8); start_pulse at cycle 1; busy=0 and phase_idx=1 from cycle 9; no frame_done.
- Continue: en pulse at cycle 12 -> mul_en=1 cycles 13-20; mul_sel=2 (13-16), 3 (17-20); start_pulse at cycle 13; frame_done=1 at cycle 21 only; mul_sel=0, phase_idx=0 from cycle 21.
- Defaults, cont=1, en pulse at cycle 0 -> mul_en=1 cycles 1-16 without gap; mul_sel 0,1,2,3 each 4 cycles; start_pulse at cycles 1 and 9; frame_done at cycle 17.
- Overrun: en at cycle 0, en again at cycle 5 -> sequence unchanged (cycles 1-8); overrun=1 from cycle 6 and held through the next frame; clr pulse -> overrun=0 next cycle.
- Abort: en at cycle 0, clr and en both high at cycle 3 -> from cycle 4: mul_en=0, mul_sel=0, IDLE, no frame_done; a later en restarts from phase 0 with mul_sel=0.
- N_PHASE=4, SEL_PER_PHASE=1, BURST_LEN=2, cont=1, en at cycle 0 -> mul_sel 0,0,1,1,2,2,3,3 on cycles 1-8; start_pulse at cycles 1, 3, 5, 7; frame_done at cycle 9. Reset asserted at cycle 4 -> all outputs 0 immediately.
